// File: rtl/median_window_loader.sv
// ---------------------------------------------------------------------------
// median_window_loader
//   Upstream feeder for the 12-input median/sort network. Collects a
//   valid/ready stream of W-bit samples into an N-word sliding window and
//   presents each complete window as one registered, stable vector.
//   Word i of win_data drives sorter input data_i. Consecutive windows are
//   offset by STRIDE samples (STRIDE < N overlaps, STRIDE == N does not).
//
// Handshake rule (both ports): a transfer happens at a rising clk edge when
//   valid && ready are both high. A producer holds valid and data stable
//   until the transfer; ready may depend combinationally on flush/rst_n.
//
// Ports
//   clk        in   1    single clock, rising edge
//   rst_n      in   1    asynchronous, active-low reset
//   in_valid   in   1    upstream sample valid
//   in_ready   out  1    sample accepted this cycle (combinational)
//   in_data    in   W    sample
//   flush      in   1    synchronous discard of partial or complete window
//   win_valid  out  1    win_data holds a complete window
//   win_ready  in   1    downstream consumes the window
//   win_data   out  N*W  word i = win_data[i*W +: W]; word 0 oldest
//   win_seq    out  16   count of windows consumed, modulo 2^16
// ---------------------------------------------------------------------------
module median_window_loader #(
    parameter int N      = 12,
    parameter int W      = 32,
    parameter int STRIDE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             flush,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [N*W-1:0]   win_data,
    output logic [15:0]      win_seq
);

    localparam int CW = $clog2(N + 1);

    generate
        if (STRIDE < 1 || STRIDE > N) begin : g_bad_stride
            $error("median_window_loader: STRIDE must be in 1..N");
        end
    endgenerate

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        PRESENT = 2'd1,
        SLIDE   = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   fill_cnt;
    logic [CW-1:0]   slide_cnt;
    logic [15:0]     seq_q;
    logic            accept;

    // Ready drops immediately on flush or reset so no sample is lost into a
    // window that is being discarded.
    assign in_ready = rst_n && !flush && (state == FILL || state == SLIDE);
    assign accept   = in_valid && in_ready;
    assign win_seq  = seq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            fill_cnt  <= '0;
            slide_cnt <= '0;
            win_data  <= '0;
            seq_q     <= '0;
            win_valid <= 1'b0;
        end else if (flush) begin
            // Flush beats a simultaneous window handshake: seq_q is untouched.
            state     <= FILL;
            fill_cnt  <= '0;
            slide_cnt <= '0;
            win_data  <= '0;
            win_valid <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        // Oldest word falls out at word 0, newest enters at word N-1.
                        win_data <= {in_data, win_data[N*W-1:W]};
                        if (fill_cnt == CW'(N - 1)) begin
                            fill_cnt  <= '0;
                            state     <= PRESENT;
                            win_valid <= 1'b1;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (win_ready) begin
                        seq_q     <= seq_q + 16'd1;
                        slide_cnt <= '0;
                        state     <= SLIDE;
                        win_valid <= 1'b0;
                    end
                end
                SLIDE: begin
                    if (accept) begin
                        win_data <= {in_data, win_data[N*W-1:W]};
                        if (slide_cnt == CW'(STRIDE - 1)) begin
                            slide_cnt <= '0;
                            state     <= PRESENT;
                            win_valid <= 1'b1;
                        end else begin
                            slide_cnt <= slide_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= FILL;
                    fill_cnt  <= '0;
                    slide_cnt <= '0;
                    win_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_median_window_loader.sv
// ---------------------------------------------------------------------------
// tb_median_window_loader
//   Bench for median_window_loader. Instance dut uses STRIDE=1 and is tracked
//   by a reference model built on the stream history: the window is always
//   the last N accepted samples (zero padded), and a window is pending when
//   more windows exist (1 + (accepts-N)/STRIDE) than have been consumed.
//   Instance dut12 uses STRIDE=12 for the non-overlapping case.
// ---------------------------------------------------------------------------
module tb_median_window_loader;

    localparam int N = 12;
    localparam int W = 32;
    localparam int STRIDE1 = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // STRIDE=1 instance
    logic           in_valid, in_ready, flush, win_valid, win_ready;
    logic [W-1:0]   in_data;
    logic [N*W-1:0] win_data;
    logic [15:0]    win_seq;

    // STRIDE=12 instance
    logic           in_valid_b, in_ready_b, flush_b, win_valid_b, win_ready_b;
    logic [W-1:0]   in_data_b;
    logic [N*W-1:0] win_data_b;
    logic [15:0]    win_seq_b;

    median_window_loader #(.N(N), .W(W), .STRIDE(STRIDE1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .flush(flush),
        .win_valid(win_valid), .win_ready(win_ready),
        .win_data(win_data), .win_seq(win_seq)
    );

    median_window_loader #(.N(N), .W(W), .STRIDE(12)) dut12 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .flush(flush_b),
        .win_valid(win_valid_b), .win_ready(win_ready_b),
        .win_data(win_data_b), .win_seq(win_seq_b)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    logic [W-1:0]   hist[$];
    int             acc;
    int             cons;
    logic [15:0]    seq_m;

    logic           drv_v, drv_r, drv_f;
    logic [W-1:0]   drv_d;
    logic           exp_valid, exp_ready;
    logic [N*W-1:0] exp_data;
    logic [15:0]    exp_seq;

    task automatic model_clear();
        hist.delete();
        acc  = 0;
        cons = 0;
    endtask

    function automatic logic [N*W-1:0] model_win();
        logic [N*W-1:0] v;
        int idx;
        v = '0;
        for (int i = 0; i < N; i++) begin
            idx = hist.size() - N + i;
            if (idx >= 0) v[i*W +: W] = hist[idx];
        end
        return v;
    endfunction

    function automatic logic model_pending();
        int avail;
        avail = (acc >= N) ? 1 + (acc - N) / STRIDE1 : 0;
        return avail > cons;
    endfunction

    // Apply inputs at posedge+1 and compute what the outputs must be now.
    task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        drv_v = v; drv_d = d; drv_r = r; drv_f = f;
        in_valid = v; in_data = d; win_ready = r; flush = f;
        #1;
        exp_valid = model_pending();
        exp_ready = rst_n && !f && !exp_valid;
        exp_data  = model_win();
        exp_seq   = seq_m;
    endtask

    // Commit the transfers the model expects at the coming edge, then step.
    task automatic advance();
        if (drv_f) begin
            model_clear();
        end else begin
            if (drv_v && exp_ready) begin
                hist.push_back(drv_d);
                acc++;
                if (hist.size() > N) void'(hist.pop_front());
            end
            if (exp_valid && drv_r) begin
                cons++;
                seq_m = seq_m + 16'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 0; in_data = '0; win_ready = 0; flush = 0;
        in_valid_b = 0; in_data_b = '0; win_ready_b = 1; flush_b = 0;
        seq_m = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL reset_win_valid got=%b want=0", win_valid); end
        checks++; if (win_data !== '0) begin failures++; $display("FAIL reset_win_data got=%h want=0", win_data); end
        checks++; if (win_seq !== 16'h0) begin failures++; $display("FAIL reset_win_seq got=%h want=0", win_seq); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(0, '0, 0, 0);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_fill();
        logic [W-1:0] wexp;
        for (int k = 1; k <= N; k++) begin
            drive(1, W'(k), 1, 0);
            checks++; if (win_valid !== exp_valid) begin failures++; $display("FAIL fill_valid k=%0d got=%b want=%b", k, win_valid, exp_valid); end
            checks++; if (in_ready !== exp_ready) begin failures++; $display("FAIL fill_ready k=%0d got=%b want=%b", k, in_ready, exp_ready); end
            checks++; if (win_data !== exp_data) begin failures++; $display("FAIL fill_data k=%0d got=%h want=%h", k, win_data, exp_data); end
            advance();
        end
        drive(0, '0, 1, 0);
        checks++; if (win_valid !== 1'b1) begin failures++; $display("FAIL first_win_valid got=%b want=1", win_valid); end
        for (int i = 0; i < N; i++) begin
            wexp = W'(i + 1);
            checks++; if (win_data[i*W +: W] !== wexp) begin failures++; $display("FAIL first_win_word%0d got=%0d want=%0d", i, win_data[i*W +: W], wexp); end
        end
        checks++; if (win_seq !== 16'd0) begin failures++; $display("FAIL first_win_seq got=%0d want=0", win_seq); end
        advance();
        // STRIDE=1: one more sample yields window 2..13
        drive(1, W'(13), 1, 0);
        checks++; if (win_seq !== 16'd1) begin failures++; $display("FAIL seq_after_hs got=%0d want=1", win_seq); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL slide_ready got=%b want=1", in_ready); end
        advance();
        drive(0, '0, 1, 0);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL present_ready got=%b want=0", in_ready); end
        for (int i = 0; i < N; i++) begin
            wexp = W'(i + 2);
            checks++; if (win_data[i*W +: W] !== wexp) begin failures++; $display("FAIL second_win_word%0d got=%0d want=%0d", i, win_data[i*W +: W], wexp); end
        end
        advance();
    endtask

    task automatic test_backpressure();
        logic [N*W-1:0] held;
        drive(1, W'(14), 0, 0);
        advance();
        held = '0;
        for (int i = 0; i < N; i++) held[i*W +: W] = W'(i + 3);
        for (int c = 0; c < 5; c++) begin
            drive(1, W'(15), 0, 0);
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready c=%0d got=%b want=0", c, in_ready); end
            checks++; if (win_valid !== 1'b1) begin failures++; $display("FAIL bp_valid c=%0d got=%b want=1", c, win_valid); end
            checks++; if (win_data !== held) begin failures++; $display("FAIL bp_data c=%0d got=%h want=%h", c, win_data, held); end
            advance();
        end
        drive(1, W'(15), 1, 0);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_hs_ready got=%b want=0", in_ready); end
        advance();
        drive(1, W'(15), 1, 0);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_accept_ready got=%b want=1", in_ready); end
        advance();
        drive(0, '0, 1, 0);
        checks++; if (win_data[(N-1)*W +: W] !== W'(15)) begin failures++; $display("FAIL bp_newest got=%0d want=15", win_data[(N-1)*W +: W]); end
        checks++; if (win_data !== exp_data) begin failures++; $display("FAIL bp_window got=%h want=%h", win_data, exp_data); end
        advance();
    endtask

    task automatic test_flush();
        logic [15:0] seq_before;
        drive(0, '0, 0, 1);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b want=0", in_ready); end
        advance();
        for (int k = 0; k < 7; k++) begin
            drive(1, W'($urandom), 1, 0);
            advance();
        end
        drive(1, W'(99), 1, 1);
        advance();
        drive(0, '0, 1, 0);
        checks++; if (win_data !== '0) begin failures++; $display("FAIL flush_data got=%h want=0", win_data); end
        for (int k = 0; k < N; k++) begin
            drive(1, W'($urandom), 0, 0);
            checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL refill_valid k=%0d got=%b want=0", k, win_valid); end
            advance();
        end
        drive(0, '0, 0, 0);
        checks++; if (win_valid !== 1'b1) begin failures++; $display("FAIL refill_done got=%b want=1", win_valid); end
        checks++; if (win_data !== exp_data) begin failures++; $display("FAIL refill_data got=%h want=%h", win_data, exp_data); end
        seq_before = seq_m;
        advance();
        drive(0, '0, 1, 1);
        advance();
        drive(0, '0, 0, 0);
        checks++; if (win_seq !== seq_before) begin failures++; $display("FAIL flush_hs_seq got=%0d want=%0d", win_seq, seq_before); end
        checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL flush_hs_valid got=%b want=0", win_valid); end
        advance();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 39) == 0);
            checks++; if (win_valid !== exp_valid) begin failures++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, win_valid, exp_valid); end
            checks++; if (in_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, in_ready, exp_ready); end
            checks++; if (win_data !== exp_data) begin failures++; $display("FAIL rnd_data c=%0d got=%h want=%h", c, win_data, exp_data); end
            checks++; if (win_seq !== exp_seq) begin failures++; $display("FAIL rnd_seq c=%0d got=%0d want=%0d", c, win_seq, exp_seq); end
            advance();
        end
    endtask

    task automatic test_stride12();
        int next;
        int seen;
        logic [W-1:0] wexp;
        next = 1;
        seen = 0;
        win_ready_b = 1'b1;
        for (int c = 0; c < 80; c++) begin
            in_valid_b = (next <= 24);
            in_data_b  = W'(next);
            #1;
            if (win_valid_b) begin
                for (int i = 0; i < N; i++) begin
                    wexp = W'(seen * 12 + i + 1);
                    checks++; if (win_data_b[i*W +: W] !== wexp) begin failures++; $display("FAIL s12_win%0d_word%0d got=%0d want=%0d", seen, i, win_data_b[i*W +: W], wexp); end
                end
                seen++;
            end
            if (in_valid_b && in_ready_b) next++;
            @(posedge clk);
            #1;
        end
        in_valid_b = 1'b0;
        checks++; if (seen !== 2) begin failures++; $display("FAIL s12_windows got=%0d want=2", seen); end
        checks++; if (win_seq_b !== 16'd2) begin failures++; $display("FAIL s12_seq got=%0d want=2", win_seq_b); end
    endtask

    task automatic test_async_reset_and_wrap();
        drive(0, '0, 0, 1);
        advance();
        for (int k = 0; k < N; k++) begin
            drive(1, W'($urandom), 0, 0);
            advance();
        end
        drive(0, '0, 1, 0);
        advance();
        // Now sliding: assert reset between edges
        drive(1, W'(7), 0, 0);
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL async_ready got=%b want=0", in_ready); end
        checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL async_valid got=%b want=0", win_valid); end
        checks++; if (win_data !== '0) begin failures++; $display("FAIL async_data got=%h want=0", win_data); end
        checks++; if (win_seq !== 16'h0) begin failures++; $display("FAIL async_seq got=%h want=0", win_seq); end
        in_valid = 1'b0;
        model_clear();
        seq_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        force dut.seq_q = 16'hFFFF;
        #1;
        release dut.seq_q;
        seq_m = 16'hFFFF;
        for (int k = 0; k < N; k++) begin
            drive(1, W'($urandom), 0, 0);
            advance();
        end
        drive(0, '0, 1, 0);
        checks++; if (win_seq !== 16'hFFFF) begin failures++; $display("FAIL wrap_pre got=%h want=ffff", win_seq); end
        checks++; if (win_valid !== 1'b1) begin failures++; $display("FAIL wrap_valid got=%b want=1", win_valid); end
        advance();
        drive(0, '0, 0, 0);
        checks++; if (win_seq !== 16'h0000) begin failures++; $display("FAIL wrap_post got=%h want=0000", win_seq); end
        advance();
    endtask

    initial begin
        test_reset();
        test_stride12();
        test_fill();
        test_backpressure();
        test_flush();
        test_random();
        test_async_reset_and_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
